branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/lc3b_types.sv | 22 ++
 rtl/bp_counter.sv | 22 ++
 rtl/branch_predictor.sv | 116 +++++++++++
 tb/tb_branch_predictor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b branch predictor.
//   lc3b_word        : 16-bit machine word / PC
//   lc3b_bp_counter  : 2-bit saturating direction counter
//   lc3b_btb_entry   : one BTB line (valid, zero-extended tag, target, counter)
//   BP_COUNTER_INIT  : counter value after reset / on a lookup miss (weakly not-taken)
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_bp_counter;

    localparam lc3b_bp_counter BP_COUNTER_INIT = 2'b01;

    // Tag is stored zero-extended to a full word so the struct is independent
    // of the table size chosen by the instantiating module.
    typedef struct packed {
        logic           valid;
        lc3b_word       tag;
        lc3b_word       target;
        lc3b_bp_counter counter;
    } lc3b_btb_entry;

endpackage

// File: rtl/bp_counter.sv
// 2-bit saturating counter next-state logic.
//   current : present counter value
//   taken   : resolved branch direction
//   next    : counter value after applying the outcome (saturates at 00 / 11)
module bp_counter
    import lc3b_types::*;
(
    input  lc3b_bp_counter current,
    input  logic           taken,
    output lc3b_bp_counter next
);

    always_comb begin
        next = current;
        if (taken) begin
            if (current != 2'b11) next = current + 2'b01;
        end else begin
            if (current != 2'b00) next = current - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a 2-bit global history.
// Optional macro: BRANCH_PREDICTOR_GSHARE_EN -- XORs the history into the low
// two index bits (fetch uses the live BHR, update uses upd_bhr).
// Ports:
//   clk, reset_n (async, active-low)
//   fetch_pc   : fetch PC, looked up combinationally
//   branch     : {counter[20:19], bhr[18:17], target[16:1], hit[0]}
//   upd_valid/upd_pc/upd_taken/upd_target/upd_bhr/upd_pred : resolved branch
//   mispredict : registered mispredict flag for the previous cycle's update
module branch_predictor
    import lc3b_types::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  lc3b_word    fetch_pc,
    output logic [20:0] branch,
    input  logic        upd_valid,
    input  lc3b_word    upd_pc,
    input  logic        upd_taken,
    input  lc3b_word    upd_target,
    input  logic [1:0]  upd_bhr,
    input  logic [20:0] upd_pred,
    output logic        mispredict
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    lc3b_btb_entry r_table [ENTRIES];
    logic [1:0]    r_bhr;
    logic          r_mispredict;

    logic [INDEX_BITS-1:0] w_fidx;
    logic [INDEX_BITS-1:0] w_uidx;
    lc3b_word              w_ftag;
    lc3b_word              w_utag;
    lc3b_btb_entry         w_fent;
    lc3b_btb_entry         w_uent;
    logic                  w_fhit;
    logic                  w_uhit;
    lc3b_bp_counter        w_unext;
    logic                  w_pred_taken;
    logic                  w_mispredict;
    logic                  w_unused;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    assign w_fidx = fetch_pc[INDEX_BITS:1] ^ INDEX_BITS'(r_bhr);
    assign w_uidx = upd_pc[INDEX_BITS:1]   ^ INDEX_BITS'(upd_bhr);
`else
    assign w_fidx = fetch_pc[INDEX_BITS:1];
    assign w_uidx = upd_pc[INDEX_BITS:1];
`endif

    assign w_ftag = lc3b_word'(fetch_pc >> (INDEX_BITS + 1));
    assign w_utag = lc3b_word'(upd_pc   >> (INDEX_BITS + 1));

    assign w_fent = r_table[w_fidx];
    assign w_uent = r_table[w_uidx];
    assign w_fhit = w_fent.valid && (w_fent.tag == w_ftag);
    assign w_uhit = w_uent.valid && (w_uent.tag == w_utag);

    // Lookup reads registered state only, so a same-cycle update to the
    // same entry is seen on the following cycle.
    always_comb begin
        branch        = '0;
        branch[20:19] = w_fhit ? w_fent.counter : BP_COUNTER_INIT;
        branch[18:17] = r_bhr;
        branch[16:1]  = w_fhit ? w_fent.target : '0;
        branch[0]     = w_fhit;
    end

    bp_counter u_counter (
        .current (w_uent.counter),
        .taken   (upd_taken),
        .next    (w_unext)
    );

    assign w_pred_taken = upd_pred[0] & upd_pred[20];
    assign w_mispredict = upd_valid &
                          ((w_pred_taken ^ upd_taken) |
                           (w_pred_taken & (upd_pred[16:1] != upd_target)));

    // Bits only consumed in some build configurations.
    assign w_unused = ^{upd_pred[18:17], upd_bhr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_table[i].valid   <= 1'b0;
                r_table[i].tag     <= '0;
                r_table[i].target  <= '0;
                r_table[i].counter <= BP_COUNTER_INIT;
            end
            r_bhr        <= 2'b00;
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= w_mispredict;
            if (upd_valid) begin
                r_bhr <= {r_bhr[0], upd_taken};
                if (w_uhit) begin
                    r_table[w_uidx].counter <= w_unext;
                    if (upd_taken) r_table[w_uidx].target <= upd_target;
                end else if (upd_taken) begin
                    r_table[w_uidx].valid   <= 1'b1;
                    r_table[w_uidx].tag     <= w_utag;
                    r_table[w_uidx].target  <= upd_target;
                    r_table[w_uidx].counter <= 2'b10;
                end
            end
        end
    end

    assign mispredict = r_mispredict;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised bench for branch_predictor with a behavioural table model.
module tb_branch_predictor;

    localparam int IB = 3;
    localparam int N  = 1 << IB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] fetch_pc;
    logic [20:0] branch;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic [1:0]  upd_bhr;
    logic [20:0] upd_pred;
    logic        mispredict;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    bit          m_valid [N];
    logic [15:0] m_tag   [N];
    logic [15:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [1:0]  m_bhr;
    logic        m_mis;

    branch_predictor #(.INDEX_BITS(IB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_pc   (fetch_pc),
        .branch     (branch),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .upd_bhr    (upd_bhr),
        .upd_pred   (upd_pred),
        .mispredict (mispredict)
    );

    always #5 clk = ~clk;

    function automatic int midx(input logic [15:0] pc, input logic [1:0] bhr);
        int ix;
        ix = int'(pc >> 1) % N;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        ix = ix ^ int'(bhr);
`endif
        return ix;
    endfunction

    function automatic logic [20:0] mpredict(input logic [15:0] pc);
        int i;
        logic [15:0] t;
        i = midx(pc, m_bhr);
        t = pc >> (IB + 1);
        if (m_valid[i] && m_tag[i] == t)
            return {2'(m_ctr[i]), m_bhr, m_tgt[i], 1'b1};
        return {2'b01, m_bhr, 16'h0000, 1'b0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bhr = 2'b00;
        m_mis = 1'b0;
    endtask

    task automatic model_update();
        logic pt;
        int i;
        logic [15:0] t;
        if (!upd_valid) begin
            m_mis = 1'b0;
            return;
        end
        pt    = upd_pred[0] & upd_pred[20];
        m_mis = (pt != upd_taken) || (pt && (upd_pred[16:1] != upd_target));
        i = midx(upd_pc, upd_bhr);
        t = upd_pc >> (IB + 1);
        if (m_valid[i] && m_tag[i] == t) begin
            if (upd_taken) begin
                if (m_ctr[i] < 3) m_ctr[i]++;
                m_tgt[i] = upd_target;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_tgt[i]   = upd_target;
            m_ctr[i]   = 2;
        end
        m_bhr = {m_bhr[0], upd_taken};
    endtask

    task automatic chk(input string nm, input logic [20:0] act, input logic [20:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        chk("branch", branch, mpredict(fetch_pc));
        chk("mispredict", 21'(mispredict), 21'(m_mis));
        @(posedge clk);
        if (reset_n) model_update();
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [15:0] pc, input logic tk,
                           input logic [15:0] tg, input logic [20:0] pr);
        upd_valid  = v;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
        upd_pred   = pr;
        upd_bhr    = m_bhr;
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            fetch_pc = 16'($urandom_range(0, 31)) << 1;
            set_upd(($urandom % 4) != 0, 16'($urandom_range(0, 31)) << 1,
                    1'($urandom), 16'($urandom) & 16'hFFFE, 21'h0);
            upd_pred = ($urandom % 2) ? mpredict(upd_pc) : 21'($urandom);
            if (($urandom % 4) == 0) upd_bhr = 2'($urandom);
            cycle();
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        fetch_pc = 16'h0040;
        model_reset();
        set_upd(1'b0, 16'h0, 1'b0, 16'h0, 21'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // reset state
        chk("reset_branch", branch, 21'h080000);
        chk("reset_mispredict", 21'(mispredict), 21'h0);
        cycle();

        // first taken update allocates
        set_upd(1'b1, 16'h0040, 1'b1, 16'h0100, 21'h080000);
        cycle();
        upd_valid = 1'b0;
        #1;
        chk("alloc_mispredict", 21'(mispredict), 21'h1);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
        chk("alloc_branch", branch, 21'h120201);
`endif
        cycle();

        // saturation up, then down
        for (int k = 0; k < 3; k++) begin
            set_upd(1'b1, 16'h0040, 1'b1, 16'h0100, 21'h0);
            cycle();
        end
        upd_valid = 1'b0;
        #1;
`ifndef BRANCH_PREDICTOR_GSHARE_EN
        chk("ctr_sat_hi", 21'(branch[20:19]), 21'h3);
`endif
        for (int k = 0; k < 2; k++) begin
            set_upd(1'b1, 16'h0040, 1'b0, 16'h0100, 21'h0);
            cycle();
        end
        upd_valid = 1'b0;
        #1;
`ifndef BRANCH_PREDICTOR_GSHARE_EN
        chk("ctr_down", 21'(branch[20:19]), 21'h1);
`endif

        // not-taken miss: no allocation, history shifts in 0
        set_upd(1'b1, 16'h0080, 1'b0, 16'h0500, 21'h080000);
        cycle();
        upd_valid = 1'b0;
        #1;
        chk("nt_miss_mispredict", 21'(mispredict), 21'h0);
        chk("nt_miss_bhr", 21'(branch[18:17]), 21'h0);
        fetch_pc = 16'h0080;
        #1;
        chk("nt_miss_nohit", 21'(branch[0]), 21'h0);
        cycle();

        // same-cycle lookup and update to one index
        fetch_pc = 16'h0040;
        set_upd(1'b1, 16'h0040, 1'b1, 16'h0200, 21'h0);
        #1;
`ifndef BRANCH_PREDICTOR_GSHARE_EN
        chk("rbw_old_target", 21'(branch[16:1]), 21'h0100);
`endif
        cycle();
        upd_valid = 1'b0;
        #1;
`ifndef BRANCH_PREDICTOR_GSHARE_EN
        chk("rbw_new_target", 21'(branch[16:1]), 21'h0200);
        chk("rbw_new_ctr", 21'(branch[20:19]), 21'h2);
`endif
        cycle();

        rand_cycles(600);

        // reset asserted in the middle of an update
        set_upd(1'b1, 16'h0040, 1'b1, 16'h0300, 21'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_branch", branch, 21'h080000);
        chk("midreset_mispredict", 21'(mispredict), 21'h0);
        fetch_pc = 16'h0012;
        #1;
        chk("midreset_branch2", branch, 21'h080000);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        fetch_pc = 16'h0040;
        #1;
        chk("post_reset_miss", 21'(branch[0]), 21'h0);
        cycle();

        // next update applies normally
        set_upd(1'b1, 16'h0040, 1'b1, 16'h0300, 21'h0);
        cycle();
        upd_valid = 1'b0;
        #1;
`ifndef BRANCH_PREDICTOR_GSHARE_EN
        chk("post_reset_alloc", branch, 21'h120601);
`endif
        rand_cycles(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
